// File: rtl/acq_in_fifo_if.sv
// Handshake bundle between the acquisition sample FIFO and its producer/consumer.
// Signal names match the original flat port list for drop-in wiring.
interface acq_in_fifo_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic              WR_EN;
  logic [DATA_W-1:0] WR_DATA;
  logic              FULL;
  logic              RD_EN;
  logic [DATA_W-1:0] RD_DATA;
  logic              RD_VALID;
  logic              EMPTY;
  logic              FIFO_VALID;
  logic [ADDR_W:0]   LEVEL;
  logic [ADDR_W:0]   MAX_LEVEL;
  logic              OVERFLOW;
  logic              UNDERFLOW;
  logic              FLUSH;
  logic              CLR_FLAGS;

  modport master (
    output WR_EN, WR_DATA, RD_EN, FLUSH, CLR_FLAGS,
    input  FULL, RD_DATA, RD_VALID, EMPTY, FIFO_VALID, LEVEL, MAX_LEVEL,
           OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  WR_EN, WR_DATA, RD_EN, FLUSH, CLR_FLAGS,
    output FULL, RD_DATA, RD_VALID, EMPTY, FIFO_VALID, LEVEL, MAX_LEVEL,
           OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/acq_in_fifo.sv
// Upstream sample buffer for the acquisition controller: circular RAM FIFO with
// fill-threshold valid, registered pop data, sticky error flags and peak watermark.
module acq_in_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int THRESH = 8
) (
  input  logic         CLK,
  input  logic         RST,
  acq_in_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef logic [ADDR_W:0] cnt_t;
  localparam cnt_t DEPTH_L  = cnt_t'(DEPTH);
  localparam cnt_t THRESH_L = cnt_t'(THRESH);

  logic [DATA_W-1:0] mem [DEPTH];

  cnt_t              wr_ptr_q, wr_ptr_d;
  cnt_t              rd_ptr_q, rd_ptr_d;
  cnt_t              level_q, level_d;
  cnt_t              max_q, max_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              fv_q, fv_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_acc, rd_acc;

  always_comb begin
    wr_acc     = bus.WR_EN && !full_q  && !bus.FLUSH;
    rd_acc     = bus.RD_EN && !empty_q && !bus.FLUSH;

    wr_ptr_d   = wr_ptr_q + cnt_t'(wr_acc);
    rd_ptr_d   = rd_ptr_q + cnt_t'(rd_acc);
    level_d    = level_q + cnt_t'(wr_acc) - cnt_t'(rd_acc);
    rd_valid_d = rd_acc;
    rd_data_d  = rd_acc ? mem[rd_ptr_q[ADDR_W-1:0]] : rd_data_q;

    if (bus.FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    // Status flags derive from next level so they move in the same cycle as LEVEL.
    full_d  = (level_d == DEPTH_L);
    empty_d = (level_d == '0);
    fv_d    = (level_d >= THRESH_L);

    // A set event beats a same-cycle clear.
    ovf_d = (ovf_q && !bus.CLR_FLAGS) || (bus.WR_EN && full_q  && !bus.FLUSH);
    udf_d = (udf_q && !bus.CLR_FLAGS) || (bus.RD_EN && empty_q && !bus.FLUSH);

    if (bus.CLR_FLAGS)        max_d = level_d;
    else if (level_d > max_q) max_d = level_d;
    else                      max_d = max_q;
  end

  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wr_ptr_q[ADDR_W-1:0]] <= bus.WR_DATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      max_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      fv_q       <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      max_q      <= max_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      fv_q       <= fv_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.FULL       = full_q;
  assign bus.EMPTY      = empty_q;
  assign bus.FIFO_VALID = fv_q;
  assign bus.LEVEL      = level_q;
  assign bus.MAX_LEVEL  = max_q;
  assign bus.OVERFLOW   = ovf_q;
  assign bus.UNDERFLOW  = udf_q;
  assign bus.RD_VALID   = rd_valid_q;
  assign bus.RD_DATA    = rd_data_q;

endmodule

// File: tb/tb_acq_in_fifo.sv
// Self-checking bench for acq_in_fifo: vector table for fill/drain, queue model
// with read-data scoreboard, and hand sequences for overflow, flush and reset.
module tb_acq_in_fifo;
  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int TH    = 8;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acq_in_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  acq_in_fifo #(.DATA_W(DW), .ADDR_W(AW), .THRESH(TH)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] sb[$];
  logic          m_ovf, m_udf, m_rdv;
  int            m_max;

  typedef struct {
    logic          we;
    logic [DW-1:0] wd;
    logic          re;
    int            e_level;
    logic          e_fv;
    logic          e_rdv;
    logic [DW-1:0] e_data;
  } vec_t;
  vec_t tbl[17];

  task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %b required %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    sb.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rdv = 1'b0;
    m_max = 0;
  endfunction

  task automatic check_model();
    logic [DW-1:0] exp_d;
    chkw("LEVEL", DW'(bus.LEVEL), DW'(mq.size()));
    chk1("EMPTY", bus.EMPTY, mq.size() == 0);
    chk1("FULL", bus.FULL, mq.size() == DEPTH);
    chk1("FIFO_VALID", bus.FIFO_VALID, mq.size() >= TH);
    chk1("OVERFLOW", bus.OVERFLOW, m_ovf);
    chk1("UNDERFLOW", bus.UNDERFLOW, m_udf);
    chkw("MAX_LEVEL", DW'(bus.MAX_LEVEL), DW'(m_max));
    chk1("RD_VALID", bus.RD_VALID, m_rdv);
    if (m_rdv && sb.size() > 0) begin
      exp_d = sb.pop_front();
      chkw("RD_DATA", bus.RD_DATA, exp_d);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then sample 1ns after the edge.
  task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re,
                       input logic fl = 1'b0, input logic cl = 1'b0);
    bit full, empty, pop_ok, wr_ok;
    bus.WR_EN     = we;
    bus.WR_DATA   = wd;
    bus.RD_EN     = re;
    bus.FLUSH     = fl;
    bus.CLR_FLAGS = cl;
    full   = (mq.size() == DEPTH);
    empty  = (mq.size() == 0);
    pop_ok = re && !empty && !fl;
    wr_ok  = we && !full && !fl;
    if (cl) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (we && full && !fl) m_ovf = 1'b1;
    if (re && empty && !fl) m_udf = 1'b1;
    m_rdv = pop_ok;
    if (fl) mq.delete();
    else begin
      if (pop_ok) sb.push_back(mq.pop_front());
      if (wr_ok) mq.push_back(wd);
    end
    if (cl) m_max = mq.size();
    else if (mq.size() > m_max) m_max = mq.size();
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    rst           = 1'b1;
    bus.WR_EN     = 1'b0;
    bus.WR_DATA   = '0;
    bus.RD_EN     = 1'b0;
    bus.FLUSH     = 1'b0;
    bus.CLR_FLAGS = 1'b0;
    model_reset();

    for (int i = 0; i < 8; i++) begin
      tbl[i].we = 1'b1; tbl[i].wd = DW'(32'h100 + i); tbl[i].re = 1'b0;
      tbl[i].e_level = i + 1; tbl[i].e_fv = (i + 1 >= TH);
      tbl[i].e_rdv = 1'b0; tbl[i].e_data = '0;
    end
    for (int j = 0; j < 8; j++) begin
      tbl[8+j].we = 1'b0; tbl[8+j].wd = '0; tbl[8+j].re = 1'b1;
      tbl[8+j].e_level = 7 - j; tbl[8+j].e_fv = 1'b0;
      tbl[8+j].e_rdv = 1'b1; tbl[8+j].e_data = DW'(32'h100 + j);
    end
    tbl[16].we = 1'b0; tbl[16].wd = '0; tbl[16].re = 1'b0;
    tbl[16].e_level = 0; tbl[16].e_fv = 1'b0; tbl[16].e_rdv = 1'b0; tbl[16].e_data = '0;

    repeat (2) @(posedge clk);
    #1;
    chkw("rst_LEVEL", DW'(bus.LEVEL), 0);
    chk1("rst_EMPTY", bus.EMPTY, 1'b1);
    chk1("rst_FULL", bus.FULL, 1'b0);
    chk1("rst_FIFO_VALID", bus.FIFO_VALID, 1'b0);
    chk1("rst_RD_VALID", bus.RD_VALID, 1'b0);
    chkw("rst_RD_DATA", bus.RD_DATA, 0);
    @(negedge clk);
    rst = 1'b0;

    // Fill 0x100..0x107 then drain in order.
    for (int k = 0; k < 17; k++) begin
      cycle(tbl[k].we, tbl[k].wd, tbl[k].re);
      chkw("tbl_LEVEL", DW'(bus.LEVEL), DW'(tbl[k].e_level));
      chk1("tbl_FIFO_VALID", bus.FIFO_VALID, tbl[k].e_fv);
      chk1("tbl_RD_VALID", bus.RD_VALID, tbl[k].e_rdv);
      if (tbl[k].e_rdv) chkw("tbl_RD_DATA", bus.RD_DATA, tbl[k].e_data);
    end
    chk1("tbl_EMPTY", bus.EMPTY, 1'b1);
    chk1("tbl_UNDERFLOW", bus.UNDERFLOW, 1'b0);

    // Overfill by one.
    for (int i = 0; i < 65; i++) begin
      cycle(1'b1, DW'(32'h2000 + i), 1'b0);
      if (i == 63) chk1("full_at_64", bus.FULL, 1'b1);
    end
    chk1("ovf_FULL", bus.FULL, 1'b1);
    chk1("ovf_OVERFLOW", bus.OVERFLOW, 1'b1);
    chkw("ovf_LEVEL", DW'(bus.LEVEL), 64);
    chkw("ovf_MAX", DW'(bus.MAX_LEVEL), 64);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk1("clr_OVERFLOW", bus.OVERFLOW, 1'b0);
    chkw("clr_MAX", DW'(bus.MAX_LEVEL), 64);
    for (int i = 0; i < 64; i++) cycle(1'b0, '0, 1'b1);
    chk1("drain_EMPTY", bus.EMPTY, 1'b1);

    // Write and pop together on an empty FIFO.
    cycle(1'b1, DW'(32'hAA), 1'b1);
    chkw("wr_rd_empty_LEVEL", DW'(bus.LEVEL), 1);
    chk1("wr_rd_empty_UNDERFLOW", bus.UNDERFLOW, 1'b1);
    chk1("wr_rd_empty_RD_VALID", bus.RD_VALID, 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk1("aa_RD_VALID", bus.RD_VALID, 1'b1);
    chkw("aa_RD_DATA", bus.RD_DATA, DW'(32'hAA));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Steady-state streaming at level 10 across pointer wrap.
    for (int i = 0; i < 10; i++) cycle(1'b1, DW'(32'h3000 + i), 1'b0);
    for (int i = 0; i < 200; i++) cycle(1'b1, DW'($urandom), 1'b1);
    chkw("stream_LEVEL", DW'(bus.LEVEL), 10);
    chk1("stream_OVERFLOW", bus.OVERFLOW, 1'b0);
    chk1("stream_UNDERFLOW", bus.UNDERFLOW, 1'b0);

    // Flush at level 20 with an underflow already recorded.
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, DW'(32'h4000 + i), 1'b0);
    cycle(1'b1, DW'(32'h55), 1'b1, 1'b1);
    chkw("flush_LEVEL", DW'(bus.LEVEL), 0);
    chk1("flush_EMPTY", bus.EMPTY, 1'b1);
    chk1("flush_FIFO_VALID", bus.FIFO_VALID, 1'b0);
    chk1("flush_RD_VALID", bus.RD_VALID, 1'b0);
    chk1("flush_UNDERFLOW", bus.UNDERFLOW, 1'b1);
    chk1("flush_OVERFLOW", bus.OVERFLOW, 1'b0);
    chkw("flush_MAX", DW'(bus.MAX_LEVEL), 20);
    cycle(1'b1, DW'(32'h66), 1'b0);
    cycle(1'b0, '0, 1'b1);
    chkw("post_flush_RD_DATA", bus.RD_DATA, DW'(32'h66));

    // Asynchronous reset in the middle of a read/write burst.
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(32'h5000 + i), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(32'h5100 + i), 1'b1);
    #2 rst = 1'b1;
    #1;
    chkw("arst_LEVEL", DW'(bus.LEVEL), 0);
    chk1("arst_EMPTY", bus.EMPTY, 1'b1);
    chk1("arst_FULL", bus.FULL, 1'b0);
    chk1("arst_FIFO_VALID", bus.FIFO_VALID, 1'b0);
    chk1("arst_RD_VALID", bus.RD_VALID, 1'b0);
    chkw("arst_RD_DATA", bus.RD_DATA, 0);
    chk1("arst_OVERFLOW", bus.OVERFLOW, 1'b0);
    chk1("arst_UNDERFLOW", bus.UNDERFLOW, 1'b0);
    chkw("arst_MAX", DW'(bus.MAX_LEVEL), 0);
    model_reset();
    bus.WR_EN = 1'b0;
    bus.RD_EN = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
    cycle(1'b1, DW'(32'h77), 1'b0);
    cycle(1'b0, '0, 1'b1);
    chkw("post_rst_RD_DATA", bus.RD_DATA, DW'(32'h77));
    cycle(1'b0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
